// File: rtl/clm_din_loader_if.sv
// Host write/readback bus and core handshake bundle for clm_din_loader.
// The slave side is the loader, the master side is the host plus core model.
interface clm_din_loader_if;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [15:0]  wr_data;
    logic         start;
    logic         rand_mode;
    logic         seed_load;
    logic [15:0]  seed;
    logic [511:0] Din;
    logic         Drdy;
    logic         Dvld;
    logic [127:0] Dout;
    logic [2:0]   rd_addr;
    logic [15:0]  rd_data;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output wr_en, wr_addr, wr_data, start, rand_mode, seed_load, seed,
        output Dvld, Dout, rd_addr,
        input  Din, Drdy, rd_data, busy, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, rand_mode, seed_load, seed,
        input  Dvld, Dout, rd_addr,
        output Din, Drdy, rd_data, busy, done, err
    );
endinterface

// File: rtl/clm_din_loader.sv
// Feeder for the masked AES core: assembles the 512-bit Din word from host writes,
// optionally refreshes the randomness words from an LFSR, then runs the Drdy/Dvld handshake.
module clm_din_loader #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [15:0] SEED_RST = 16'hACE1
) (
    input logic CLK,
    input logic rst,
    clm_din_loader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT} state_t;

    localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT - 1);
    localparam logic [4:0]  FILL_FIRST = 5'd8;
    localparam logic [4:0]  FILL_LAST  = 5'd30;

    state_t         state;
    logic [15:0]    lfsr;
    logic [4:0]     fill_idx;
    logic [15:0]    wait_cnt;
    logic [127:0]   res;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign bus.rd_data = res[{bus.rd_addr, 4'b0000} +: 16];

    // Seed handling precedes start so that a run started with a seed load fills from the new seed.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= SEED_RST;
            fill_idx <= FILL_FIRST;
            wait_cnt <= 16'd0;
            res      <= 128'd0;
            bus.Din  <= 512'd0;
            bus.Drdy <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        bus.Din[{bus.wr_addr, 4'b0000} +: 16] <= bus.wr_data;
                    end
                    if (bus.seed_load) begin
                        lfsr <= (bus.seed == 16'd0) ? 16'h0001 : bus.seed;
                    end
                    if (bus.start) begin
                        bus.err  <= 1'b0;
                        bus.busy <= 1'b1;
                        if (bus.rand_mode) begin
                            fill_idx <= FILL_FIRST;
                            state    <= FILL;
                        end else begin
                            bus.Drdy <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                FILL: begin
                    bus.Din[{fill_idx, 4'b0000} +: 16] <= lfsr;
                    lfsr <= lfsr_next(lfsr);
                    if (fill_idx == FILL_LAST) begin
                        bus.Drdy <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        fill_idx <= fill_idx + 5'd1;
                    end
                end
                ISSUE: begin
                    bus.Drdy <= 1'b0;
                    wait_cnt <= 16'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A valid response on the final counted cycle still wins over the timeout.
                    if (bus.Dvld) begin
                        res      <= bus.Dout;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    bus.Drdy <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clm_din_loader.sv
// Self-checking bench for clm_din_loader: table-driven runs, hand-written corner cases,
// and randomized runs checked against a word-array reference model.
module tb_clm_din_loader;

    localparam int TO = 8;

    logic clk;
    logic rst;

    clm_din_loader_if bus();

    clm_din_loader #(.TIMEOUT(TO), .SEED_RST(16'hACE1)) dut (
        .CLK(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the 32 host-visible words, LFSR, captured result and error flag.
    logic [15:0]  m_words [32];
    logic [15:0]  m_lfsr;
    logic [127:0] m_res;
    logic         m_err;

    typedef struct {
        logic [15:0]  seed;
        bit           together;
        bit           noise;
        int           dly;
        logic [127:0] dout;
        logic [15:0]  w8, w9, w10, rd7, rd0;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] model_step(input logic [15:0] s);
        int v;
        v = int'(s) / 2;
        if (int'(s) % 2 == 1) v = v ^ 32'hB400;
        return 16'(v);
    endfunction

    function automatic logic [511:0] model_din();
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[16*k +: 16] = m_words[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_words[k] = 16'h0000;
        m_lfsr = 16'hACE1;
        m_res  = '0;
        m_err  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 16'd0;
        bus.start     = 1'b0;
        bus.rand_mode = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = 16'd0;
        bus.Dvld      = 1'b0;
        bus.Dout      = '0;
    endtask

    task automatic drive_noise();
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'($urandom);
        bus.wr_data   = 16'($urandom);
        bus.start     = 1'b1;
        bus.rand_mode = 1'($urandom);
        bus.seed_load = 1'b1;
        bus.seed      = 16'($urandom);
    endtask

    task automatic write_word(input logic [4:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        idle_inputs();
        m_words[a] = d;
    endtask

    task automatic load_seed(input logic [15:0] sd);
        bus.seed_load = 1'b1;
        bus.seed      = sd;
        step();
        idle_inputs();
        m_lfsr = (sd == 16'd0) ? 16'h0001 : sd;
    endtask

    task automatic check_readback();
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            #1;
            checkOutput("rd_data", 512'(bus.rd_data), 512'(m_res[16*a +: 16]));
        end
    endtask

    // One full run: start (optionally with seed load and/or write), then dly>0 answers in WAIT cycle dly, dly<0 never answers.
    task automatic applyStimulus(input bit rm, input bit sl, input logic [15:0] sd,
                                 input bit ww, input logic [4:0] wa, input logic [15:0] wd,
                                 input int dly, input logic [127:0] dout, input bit noise);
        int lat;
        logic [511:0] exp_din;
        bus.start     = 1'b1;
        bus.rand_mode = rm;
        bus.seed_load = sl;
        bus.seed      = sd;
        bus.wr_en     = ww;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        step();
        idle_inputs();
        if (sl) m_lfsr = (sd == 16'd0) ? 16'h0001 : sd;
        if (ww) m_words[wa] = wd;
        if (rm) begin
            for (int k = 8; k <= 30; k++) begin
                m_words[k] = m_lfsr;
                m_lfsr = model_step(m_lfsr);
            end
        end
        m_err   = 1'b0;
        exp_din = model_din();
        lat     = rm ? 24 : 1;
        checkOutput("err_cleared_on_start", 512'(bus.err), 512'(m_err));
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) step();
            checkOutput("busy_in_run", 512'(bus.busy), 512'(1));
            checkOutput("drdy_timing", 512'(bus.Drdy), 512'(c == lat));
        end
        checkOutput("din_at_issue", bus.Din, exp_din);
        if (dly > 0) begin
            for (int c = 1; c <= dly; c++) begin
                step();
                checkOutput("drdy_low_in_wait", 512'(bus.Drdy), 512'(0));
                checkOutput("busy_in_wait", 512'(bus.busy), 512'(1));
                checkOutput("no_early_done", 512'(bus.done), 512'(0));
                if (noise) drive_noise();
                if (c == dly) begin
                    bus.Dvld = 1'b1;
                    bus.Dout = dout;
                end
            end
            step();
            idle_inputs();
            m_res = dout;
            checkOutput("done_pulse", 512'(bus.done), 512'(1));
            checkOutput("busy_after_done", 512'(bus.busy), 512'(0));
            checkOutput("err_after_done", 512'(bus.err), 512'(0));
            checkOutput("din_stable", bus.Din, exp_din);
            step();
            checkOutput("done_one_cycle", 512'(bus.done), 512'(0));
        end else begin
            for (int c = 1; c <= TO; c++) begin
                step();
                checkOutput("busy_before_timeout", 512'(bus.busy), 512'(1));
                checkOutput("err_before_timeout", 512'(bus.err), 512'(0));
                if (noise) drive_noise();
            end
            step();
            idle_inputs();
            m_err = 1'b1;
            checkOutput("err_on_timeout", 512'(bus.err), 512'(m_err));
            checkOutput("busy_after_timeout", 512'(bus.busy), 512'(0));
            checkOutput("no_done_on_timeout", 512'(bus.done), 512'(0));
            checkOutput("din_stable_timeout", bus.Din, exp_din);
        end
        check_readback();
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{16'h0001, 1'b0, 1'b0, 3, 128'h3925841d02dc09fbdc118597196a0b32,
                    16'h0001, 16'hB400, 16'h5A00, 16'h3925, 16'h0b32};
        vecs[1] = '{16'h0000, 1'b1, 1'b1, 1, 128'h00112233445566778899aabbccddeeff,
                    16'h0001, 16'hB400, 16'h5A00, 16'h0011, 16'heeff};
        vecs[2] = '{16'hACE1, 1'b1, 1'b0, 5, 128'hffff_0000_0000_0000_0000_0000_0000_1234,
                    16'hACE1, 16'hE270, 16'h7138, 16'hffff, 16'h1234};
        vecs[3] = '{16'h8000, 1'b0, 1'b1, TO, 128'hdead_0000_0000_0000_0000_0000_0000_cafe,
                    16'h8000, 16'h4000, 16'h2000, 16'hdead, 16'hcafe};
        vecs[4] = '{16'h0003, 1'b1, 1'b0, 2, 128'h5a5a_1111_2222_3333_4444_5555_6666_a5a5,
                    16'h0003, 16'hB401, 16'hEE00, 16'h5a5a, 16'ha5a5};
        vecs[5] = '{16'hFFFF, 1'b0, 1'b1, 4, 128'h8001_0000_0000_0000_0000_0000_0000_7ffe,
                    16'hFFFF, 16'hCBFF, 16'hD1FF, 16'h8001, 16'h7ffe};

        idle_inputs();
        bus.rd_addr = 3'd0;
        rst = 1'b1;
        model_reset();
        step();
        step();
        checkOutput("reset_din", bus.Din, 512'd0);
        checkOutput("reset_drdy", 512'(bus.Drdy), 512'(0));
        checkOutput("reset_busy", 512'(bus.busy), 512'(0));
        checkOutput("reset_done", 512'(bus.done), 512'(0));
        checkOutput("reset_err", 512'(bus.err), 512'(0));
        rst = 1'b0;
        check_readback();

        // Plaintext and p_det writes, then a plain run answered three cycles after Drdy.
        for (int k = 0; k < 8; k++) write_word(5'(k), 16'(k));
        write_word(5'd31, 16'h0015);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 5'd0, 16'h0, 3,
                      128'h3925841d02dc09fbdc118597196a0b32, 1'b0);
        checkOutput("plaintext", 512'(bus.Din[127:0]), 512'(128'h0007_0006_0005_0004_0003_0002_0001_0000));
        checkOutput("p_det", 512'(bus.Din[500:496]), 512'(5'h15));
        checkOutput("rand_words_zero", 512'(bus.Din[495:128]), 512'd0);

        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].together) load_seed(vecs[i].seed);
            applyStimulus(1'b1, vecs[i].together, vecs[i].seed, 1'b0, 5'd0, 16'h0,
                          vecs[i].dly, vecs[i].dout, vecs[i].noise);
            checkOutput("tbl_word8", 512'(bus.Din[143:128]), 512'(vecs[i].w8));
            checkOutput("tbl_word9", 512'(bus.Din[159:144]), 512'(vecs[i].w9));
            checkOutput("tbl_word10", 512'(bus.Din[175:160]), 512'(vecs[i].w10));
            checkOutput("tbl_plaintext_kept", 512'(bus.Din[127:0]), 512'(128'h0007_0006_0005_0004_0003_0002_0001_0000));
            bus.rd_addr = 3'd7;
            #1;
            checkOutput("tbl_rd7", 512'(bus.rd_data), 512'(vecs[i].rd7));
            bus.rd_addr = 3'd0;
            #1;
            checkOutput("tbl_rd0", 512'(bus.rd_data), 512'(vecs[i].rd0));
        end

        // Timeout with host noise during WAIT, then a clean run that must clear err.
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 5'd0, 16'h0, -1, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 16'h0, 2, 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10, 1'b0);

        // Dvld while idle must not capture or pulse done.
        bus.Dvld = 1'b1;
        bus.Dout = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
        step();
        checkOutput("idle_dvld_no_done", 512'(bus.done), 512'(0));
        step();
        idle_inputs();
        checkOutput("idle_dvld_no_done2", 512'(bus.done), 512'(0));
        check_readback();

        // Write committed in the same cycle as start.
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 5'd2, 16'hBEEF, 1, 128'h1, 1'b0);
        checkOutput("write_with_start", 512'(bus.Din[47:32]), 512'(16'hBEEF));

        // Reset while FILL is writing word 15.
        bus.start     = 1'b1;
        bus.rand_mode = 1'b1;
        step();
        idle_inputs();
        for (int c = 2; c <= 8; c++) step();
        rst = 1'b1;
        step();
        model_reset();
        checkOutput("midfill_rst_din", bus.Din, 512'd0);
        checkOutput("midfill_rst_busy", 512'(bus.busy), 512'(0));
        checkOutput("midfill_rst_drdy", 512'(bus.Drdy), 512'(0));
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            checkOutput("midfill_no_drdy", 512'(bus.Drdy), 512'(0));
        end
        check_readback();
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 5'd0, 16'h0, 1, 128'h2, 1'b0);
        checkOutput("lfsr_reset_seed", 512'(bus.Din[143:128]), 512'(16'hACE1));

        // Randomized operations against the model.
        for (int n = 0; n < 40; n++) begin
            int op;
            int dly;
            op = $urandom_range(0, 3);
            if (op == 0) begin
                write_word(5'($urandom), 16'($urandom));
            end else if (op == 1) begin
                load_seed(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
            end else begin
                dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, TO));
                applyStimulus(1'($urandom), 1'($urandom), 16'($urandom),
                              1'($urandom), 5'($urandom), 16'($urandom), dly,
                              {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
